dir_select_debounce: RTL
========================

// Module: dir_select_debounce
// PURPOSE
//  Upstream control stage for the 4-bit up/down T-FF counter. Takes a raw
//  bouncing direction pushbutton, synchronises and debounces it, and toggles the
//  counter's direction select S once per confirmed press.
//  A one-cycle dir_changed pulse marks each direction change for downstream logic.
//  A lock input freezes the direction during counting windows.
// PARAMETERS
//  DEB_CYCLES  16  consecutive stable synchronised samples needed to confirm a press or release (>=1)
//  DEB_W       5   debounce counter width; DEB_CYCLES-1 must fit in DEB_W bits
// PORTS
//  Clck         in   1  system clock, all flops on rising edge
//  reset        in   1  synchronous, active-high reset
//  btn_raw      in   1  raw asynchronous pushbutton, 1 = pressed
//  lock         in   1  1 = confirmed presses do not change S
//  S            out  1  direction select to counter: 0 = up, 1 = down
//  dir_changed  out  1  one-cycle pulse on the cycle S takes its new value
//  btn_level    out  1  debounced button level, 1 = pressed
// BEHAVIOUR
//  - Clocking/reset: one clock (Clck). reset is synchronous and active-high.
//  - Reset values: S=0, dir_changed=0, btn_level=0, both sync flops=0, cnt=0, state=IDLE.
//  - Reset mid-operation: any debounce in progress is aborted. A button still held
//    after reset releases is treated as a new press.
//  - Sync: btn_raw -> sync1 -> sync2 (two flops). btn_s = sync2. The FSM sees only btn_s.
//  - FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. cnt is cleared on entry to PRESS_DB or RELEASE_DB.
//    IDLE:       btn_s=1 -> PRESS_DB.
//    PRESS_DB:   btn_s=0 -> IDLE (bounce rejected, no output change).
//                btn_s=1 and cnt==DEB_CYCLES-1 -> HELD (press confirmed).
//                btn_s=1 otherwise -> cnt++.
//    HELD:       btn_s=0 -> RELEASE_DB.
//    RELEASE_DB: btn_s=1 -> HELD (no toggle).
//                btn_s=0 and cnt==DEB_CYCLES-1 -> IDLE.
//                btn_s=0 otherwise -> cnt++.
//  - On the PRESS_DB->HELD transition with lock=0: S <= ~S and dir_changed <= 1, both
//    registered and in the same edge. dir_changed is 0 on every other cycle.
//  - Locked press: if lock=1 on that transition, S holds and no pulse is issued.
//    lock is sampled only on that one cycle.
//  - Press latency: if edge k is the first edge sampling btn_raw=1 and the input stays
//    high, S and dir_changed update at edge k+DEB_CYCLES+2 (k+18 at the default).
//  - btn_level = 1 exactly when state is HELD or RELEASE_DB, registered with the state.
//  - Release never changes S. Maximum of one toggle per confirmed press; holding the
//    button forever gives no repeat.
//  - cnt never exceeds DEB_CYCLES-1 and never wraps.
//  - DEB_CYCLES=1: the first PRESS_DB cycle with btn_s=1 confirms the press.
// TESTING
//  1. reset=1 for 2 edges with btn_raw=1 -> S=0, dir_changed=0, btn_level=0;
//     after release of reset, S toggles at edge k+18 (k = first post-reset edge).
//  2. Clean press: btn_raw 0->1 at edge k, held 40 cycles, then released ->
//     S 0->1 and dir_changed=1 at edge k+18 only; release gives no S change;
//     a second clean press returns S to 0.
//  3. Press bounce: btn_raw high 10 cycles, low 3, high 10, low -> S stays 0,
//     dir_changed never asserts, btn_level stays 0.
//  4. Release bounce: in HELD, btn_raw low 5 cycles, high 2, then low for 30 ->
//     btn_level stays 1 through the bounce and falls 18 edges after the final fall;
//     S is unchanged.
//  5. Locked press: lock=1 during a clean press -> S unchanged, no pulse, btn_level=1;
//     a repeat press with lock=0 toggles S.
//  6. Reset mid-debounce: btn held, reset pulsed when cnt=8 -> no toggle before reset;
//     S=0 after reset; with btn still held, toggle at edge k+18 after reset release.

Source files
------------

// File: rtl/dir_select_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : dir_select_debounce
//  Description : Direction-select front end for the 4-bit up/down counter.
//                A raw, bouncing pushbutton is brought into the Clck domain
//                through a two-flop synchroniser and then debounced by a
//                four-state FSM. Each confirmed press toggles the direction
//                select S, unless lock is high on the confirming cycle.
//
//  Parameters  : DEB_CYCLES - stable synchronised samples needed to confirm
//                             a press or a release (>= 1)
//                DEB_W      - debounce counter width (DEB_CYCLES-1 must fit)
//
//  Ports       : Clck        in   system clock, rising edge
//                reset       in   synchronous, active-high reset
//                btn_raw     in   raw asynchronous pushbutton, 1 = pressed
//                lock        in   1 = confirmed presses leave S unchanged
//                S           out  direction select: 0 = up, 1 = down
//                dir_changed out  one-cycle pulse on the cycle S changes
//                btn_level   out  debounced button level, 1 = pressed
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dir_select_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 5
) (
    input  logic Clck,
    input  logic reset,
    input  logic btn_raw,
    input  logic lock,
    output logic S,
    output logic dir_changed,
    output logic btn_level
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [DEB_W-1:0] c_CNT_MAX = DEB_W'(DEB_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DEB_W-1:0] r_cnt;
    logic [DEB_W-1:0] w_cnt_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_s;
    logic             r_dir_changed;
    logic             r_btn_level;
    logic             w_btn_s;
    logic             w_confirm;
    logic             w_toggle;
    logic             w_btn_level_nxt;

    // Only the second synchroniser stage is ever seen by the FSM.
    assign w_btn_s = r_sync2;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous button input
    // ------------------------------------------------------------------
    always_ff @(posedge Clck) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clck) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_btn_level <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_btn_level <= w_btn_level_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM: next state / counter
    // The counter is cleared on entry to either debounce state and only
    // advances while the input stays at the level being confirmed, so it
    // saturates at c_CNT_MAX by construction (the FSM leaves on that value).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_confirm   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESS_DB;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = HELD;
                    w_confirm   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt = RELEASE_DB;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_DB: begin
                if (w_btn_s) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // lock matters only on the single confirming cycle.
    assign w_toggle        = w_confirm & ~lock;
    assign w_btn_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_DB);

    // ------------------------------------------------------------------
    // Direction select and change pulse
    // ------------------------------------------------------------------
    always_ff @(posedge Clck) begin
        if (reset) begin
            r_s           <= 1'b0;
            r_dir_changed <= 1'b0;
        end else begin
            r_dir_changed <= w_toggle;
            if (w_toggle) begin
                r_s <= ~r_s;
            end
        end
    end

    assign S           = r_s;
    assign dir_changed = r_dir_changed;
    assign btn_level   = r_btn_level;

endmodule
`default_nettype wire
